// File: rtl/sync_time_mod_calc.sv
// sync_time_mod_calc
//   Phase-alignment initialiser for the per-transducer time counters.
//   A START strobe snapshots the 64-bit system time (T0). The block then
//   computes T0 mod CYCLE[i] for each channel in turn. It uses one shared
//   serial restoring divider that takes 64 cycles per channel. Each result
//   is then presented for one cycle as a load strobe.
//
// Ports
//   CLK        : system clock, rising edge
//   RST_N      : asynchronous active-low reset
//   SYS_TIME   : free-running 64-bit system time
//   START      : run request, only honoured while idle
//   CYCLE      : per-channel period [0:DEPTH-1], held stable while BUSY
//   BUSY       : run in progress
//   LOAD_VALID : one-cycle strobe qualifying LOAD_IDX / LOAD_VAL
//   LOAD_IDX   : channel of the current result (holds between strobes)
//   LOAD_VAL   : T0 mod CYCLE[LOAD_IDX] (holds between strobes)
//   DONE       : one-cycle pulse alongside the final LOAD_VALID
module sync_time_mod_calc #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [63:0]         SYS_TIME,
    input  logic                START,
    input  logic [WIDTH-1:0]    CYCLE [0:DEPTH-1],
    output logic                BUSY,
    output logic                LOAD_VALID,
    output logic [IDX_W-1:0]    LOAD_IDX,
    output logic [WIDTH-1:0]    LOAD_VAL,
    output logic                DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [63:0]        t0_reg, t0_next;
    logic [WIDTH-1:0]   rem_reg, rem_next;
    logic [5:0]         bit_reg, bit_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               load_valid_reg, load_valid_next;
    logic               done_reg, done_next;
    logic [IDX_W-1:0]   load_idx_reg, load_idx_next;
    logic [WIDTH-1:0]   load_val_reg, load_val_next;

    // One restoring-division step. rem is always below the divisor, so it
    // is below 2^WIDTH-1. The shifted value therefore fits in WIDTH+1 bits.
    logic [WIDTH-1:0]   cyc;
    logic [WIDTH:0]     shifted;
    logic               take;
    logic [WIDTH-1:0]   rem_step;
    logic               last_chan;

    assign cyc       = CYCLE[idx_reg];
    assign shifted   = {rem_reg, t0_reg[bit_reg]};
    assign take      = (cyc != '0) && (shifted >= {1'b0, cyc});
    assign rem_step  = take ? WIDTH'(shifted - {1'b0, cyc}) : shifted[WIDTH-1:0];
    assign last_chan = (idx_reg == IDX_W'(DEPTH - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= S_IDLE;
            t0_reg         <= '0;
            rem_reg        <= '0;
            bit_reg        <= '0;
            idx_reg        <= '0;
            load_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            load_idx_reg   <= '0;
            load_val_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            t0_reg         <= t0_next;
            rem_reg        <= rem_next;
            bit_reg        <= bit_next;
            idx_reg        <= idx_next;
            load_valid_reg <= load_valid_next;
            done_reg       <= done_next;
            load_idx_reg   <= load_idx_next;
            load_val_reg   <= load_val_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        t0_next         = t0_reg;
        rem_next        = rem_reg;
        bit_next        = bit_reg;
        idx_next        = idx_reg;
        load_valid_next = 1'b0;
        done_next       = 1'b0;
        load_idx_next   = load_idx_reg;
        load_val_next   = load_val_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (START) begin
                    t0_next    = SYS_TIME;
                    idx_next   = '0;
                    rem_next   = '0;
                    bit_next   = 6'd63;
                    state_next = S_DIV;
                end
            end
            S_DIV: begin
                rem_next = rem_step;
                bit_next = bit_reg - 6'd1;
                if (bit_reg == 6'd0) begin
                    // The output registers are loaded on the final division
                    // edge, so the strobe is visible during the OUT cycle.
                    // A zero period reports 0 whatever the divider produced.
                    state_next      = S_OUT;
                    load_valid_next = 1'b1;
                    load_idx_next   = idx_reg;
                    load_val_next   = (cyc == '0) ? '0 : rem_step;
                    done_next       = last_chan;
                end
            end
            S_OUT: begin
                if (last_chan) begin
                    state_next = S_IDLE;
                end else begin
                    idx_next   = idx_reg + IDX_W'(1);
                    rem_next   = '0;
                    bit_next   = 6'd63;
                    state_next = S_DIV;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign BUSY       = (state_reg != S_IDLE);
    assign LOAD_VALID = load_valid_reg;
    assign LOAD_IDX   = load_idx_reg;
    assign LOAD_VAL   = load_val_reg;
    assign DONE       = done_reg;

endmodule

// File: tb/tb_sync_time_mod_calc.sv
module tb_sync_time_mod_calc;
    localparam int W   = 13;
    localparam int D   = 3;
    localparam int IW  = 2;
    localparam int RUN = 65 * D;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [63:0]   SYS_TIME = '0;
    logic          START = 1'b0;
    logic [W-1:0]  CYCLE [0:D-1];
    logic          BUSY, LOAD_VALID, DONE;
    logic [IW-1:0] LOAD_IDX;
    logic [W-1:0]  LOAD_VAL;

    sync_time_mod_calc #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RST_N(RST_N), .SYS_TIME(SYS_TIME), .START(START),
        .CYCLE(CYCLE), .BUSY(BUSY), .LOAD_VALID(LOAD_VALID),
        .LOAD_IDX(LOAD_IDX), .LOAD_VAL(LOAD_VAL), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a run accepted at edge s makes cycle rel = edge+1-s.
    // Channel k reports in cycle 65*(k+1) with value T0 mod CYCLE[k].
    bit          active = 0;
    bit          chk_en = 0;
    int          n = 0;
    int          start_n = 0;
    logic [63:0] m_t0 = '0;
    int          e_idx = 0;
    logic [63:0] e_val = '0;

    always @(posedge CLK) begin
        if (!RST_N) begin
            active = 0;
            e_idx  = 0;
            e_val  = '0;
        end else if (START && (!active || n >= start_n + RUN + 1)) begin
            active  = 1;
            start_n = n;
            m_t0    = SYS_TIME;
        end
        n++;
    end

    int rel;
    bit eb, ev, ed;
    always @(negedge CLK) begin
        if (chk_en) begin
            if (!RST_N) begin
                active = 0;
                e_idx  = 0;
                e_val  = '0;
            end
            rel = n - start_n;
            eb = active && rel >= 1 && rel <= RUN;
            ev = eb && (rel % 65 == 0);
            ed = eb && (rel == RUN);
            if (ev) begin
                e_idx = rel / 65 - 1;
                e_val = (CYCLE[e_idx] == '0) ? 64'd0 : m_t0 % 64'(CYCLE[e_idx]);
                $display("load idx=%0d val=%0d exp_val=%0d t0=%0d", LOAD_IDX, LOAD_VAL, e_val, m_t0);
            end
            check("busy", 64'(BUSY), 64'(eb));
            check("load_valid", 64'(LOAD_VALID), 64'(ev));
            check("done", 64'(DONE), 64'(ed));
            check("load_idx", 64'(LOAD_IDX), 64'(e_idx));
            check("load_val", 64'(LOAD_VAL), e_val);
        end
    end

    task automatic drive_edge();
        @(negedge CLK);
        #1;
    endtask

    task automatic run(input logic [63:0] t, input logic [W-1:0] c0, input logic [W-1:0] c1,
                       input logic [W-1:0] c2, input bit noisy);
        drive_edge();
        CYCLE[0] = c0; CYCLE[1] = c1; CYCLE[2] = c2;
        SYS_TIME = t;
        START = 1'b1;
        drive_edge();
        START = 1'b0;
        for (int k = 0; k < RUN + 3; k++) begin
            if (noisy) begin
                SYS_TIME = {$urandom, $urandom};
                START = (k < RUN - 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            drive_edge();
        end
        START = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_cycle();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return W'(1);
        if (r == 2) return W'(8191);
        return W'($urandom_range(2, 8191));
    endfunction

    initial begin
        CYCLE[0] = W'(7); CYCLE[1] = W'(7); CYCLE[2] = W'(7);
        chk_en = 1;
        repeat (3) drive_edge();
        RST_N = 1'b1;
        repeat (2) drive_edge();

        run(64'd1000, W'(4096), W'(4096), W'(4096), 0);
        run(64'd10000, W'(4096), W'(3), W'(4095), 0);
        run(64'hFFFF_FFFF_FFFF_FFFF, W'(4095), W'(8191), W'(1), 0);
        run(64'd12, W'(0), W'(5), W'(0), 0);
        for (int i = 0; i < 6; i++)
            run({$urandom, $urandom}, rand_cycle(), rand_cycle(), rand_cycle(), 1);

        // START held high with a counting system time: back-to-back runs.
        drive_edge();
        CYCLE[0] = W'(4093); CYCLE[1] = W'(97); CYCLE[2] = W'(8191);
        SYS_TIME = 64'h0123_4567_89AB_CDEF;
        START = 1'b1;
        for (int k = 0; k < 2 * RUN + 10; k++) begin
            drive_edge();
            SYS_TIME = SYS_TIME + 64'd1;
        end
        START = 1'b0;
        repeat (RUN + 3) drive_edge();

        // Reset asserted in cycle 100 of a run.
        drive_edge();
        CYCLE[0] = W'(1234); CYCLE[1] = W'(55); CYCLE[2] = W'(8000);
        SYS_TIME = {$urandom, $urandom};
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (99) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_load_valid", 64'(LOAD_VALID), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_load_idx", 64'(LOAD_IDX), 64'd0);
        check("rst_load_val", 64'(LOAD_VAL), 64'd0);
        repeat (3) drive_edge();
        RST_N = 1'b1;
        repeat (RUN + 10) drive_edge();
        run({$urandom, $urandom}, W'(1234), W'(55), W'(8000), 0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
